ksa_pipe_adder: RTL and testbench
=================================

Name: ksa_pipe_adder

Overview:
- Parametrised, pipelined Kogge-Stone adder/subtractor.
- Generalises the fixed 32-bit single-distance prefix stages to any power-of-two WIDTH, with all log2(WIDTH) prefix levels generated and each level registered.
- Carries a valid/ready handshake with backpressure.
- Sits in the execute pipeline as the ALU add/sub datapath for multi-cycle, high-frequency configurations.

Parameters:
- WIDTH, 32, operand width; power of two, 4..64.
- LEVELS, $clog2(WIDTH), number of prefix levels; derived, not overridable.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  input operands valid.
- o_ready  output  1  adder can accept an input this cycle.
- i_a  input  WIDTH  operand A.
- i_b  input  WIDTH  operand B.
- i_sub  input  1  1 = A-B, 0 = A+B+i_cin.
- i_cin  input  1  carry-in; ignored when i_sub=1.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts the result.
- o_sum  output  WIDTH  result.
- o_cout  output  1  carry-out of the MSB.
- o_ovf  output  1  signed overflow.

Behaviour:
- Pipeline enable: en = i_ready | ~o_valid. o_ready = en. All stage registers load only when en=1; otherwise every stage holds.
- Bubbles are not squeezed while stalled. An accepted input (i_valid & o_ready) leaves at o_valid exactly LEVELS+2 enabled cycles later: 7 cycles for WIDTH=32 with no stalls.
- Stage 0 (input register):
  - b' = i_sub ? ~i_b : i_b; c0 = i_sub ? 1 : i_cin.
  - g = i_a & b', p = i_a ^ b'.
  - Bit 0 generate is folded: g0 = (a0&b0') | (p0&c0).
  - Also registers p_orig, the MSBs of a and b', and valid.
- Stage k (1..LEVELS):
  - Distance d = 2^(k-1).
  - Bits i>=d use black-cell combine: G = Gi | (Pi & G(i-d)), P = Pi & P(i-d).
  - Bits i<d pass through.
  - p_orig, the MSBs and valid are carried alongside.
- Output stage:
  - o_sum[0] = p_orig[0]^c0; o_sum[i] = p_orig[i] ^ G[i-1].
  - o_cout = G[WIDTH-1].
  - o_ovf = (a_msb == b'_msb) & (o_sum[WIDTH-1] != a_msb).
- Valid bit per stage: loads the upstream valid when en=1, so invalid slots travel as bubbles.
- Data registers of invalid slots may hold stale values, but outputs observed while o_valid=0 are don't-care except at reset.
- Reset (i_rst_n low, asynchronous):
  - All valid bits and all data registers clear to 0.
  - o_valid=0, o_sum=0, o_cout=0, o_ovf=0.
  - o_ready=1 immediately.
  - In-flight operations are discarded. Reset release takes effect at the next i_clk edge.
- Simultaneous accept and emit in one cycle is allowed: full throughput of 1 op/cycle.
- Stall with a full pipe: o_ready=0 and every stage holds unchanged until i_ready rises.
- Arithmetic is modulo 2^WIDTH.
  - Subtraction carry semantics: o_cout=1 means no borrow.

Optional Feature:
- KSA_PIPE_FLAGS_EN
  - Defined: adds output ports o_zero (o_sum==0) and o_neg (o_sum[WIDTH-1]). Both are registered in the output stage, reset to 0, and valid with o_valid.
  - Undefined: these ports and their logic do not exist; all other behaviour is identical.

Decomposition:
- Package ksa_pkg:
  - typedef pg_t (struct of g, p vectors parameterised via WIDTH at use site).
  - Function black_combine(gi, pi, gk, pk).
  - Function ksa_levels(width).
- Sub-module ksa_prefix_level:
  - Parameters WIDTH, DIST; combinational single prefix level.
  - Instantiated LEVELS times in a generate loop, each followed by the stage register in the top.

Test Plan:
- WIDTH=32, i_a=32'h0000_0001, i_b=32'hFFFF_FFFF, i_sub=0, i_cin=0 -> after 7 cycles o_sum=0, o_cout=1, o_ovf=0.
- i_a=32'h7FFF_FFFF, i_b=1, add -> o_sum=32'h8000_0000, o_cout=0, o_ovf=1. With FLAGS_EN: o_neg=1, o_zero=0.
- i_a=5, i_b=7, i_sub=1 -> o_sum=32'hFFFF_FFFE, o_cout=0, o_ovf=0. i_a=7, i_b=7, i_sub=1 -> o_sum=0, o_cout=1. With FLAGS_EN: o_zero=1.
- Back-to-back stream of 20 random ops with i_ready=1 -> o_valid high for 20 consecutive cycles starting cycle 7; results match a reference model in order.
- Fill the pipe, hold i_ready=0 for 5 cycles -> o_ready=0, outputs stable and no loss; release -> remaining results emerge in order, one per cycle.
- Assert i_rst_n=0 mid-stream, asynchronously between edges -> o_valid and o_sum go to 0 immediately, o_ready=1. After release, a new op (3+4) gives o_sum=7 after 7 cycles with no stale results. Repeat with WIDTH=8 and WIDTH=64 for latency 5 and 8.

Source files
------------

// File: rtl/ksa_pkg.sv
// Shared types and helpers for the pipelined Kogge-Stone adder.
// pg_t is the widest generate/propagate bundle; modules narrow it to WIDTH.
package ksa_pkg;

  localparam int KSA_MAX_W = 64;

  typedef struct packed {
    logic [KSA_MAX_W-1:0] g;
    logic [KSA_MAX_W-1:0] p;
  } pg_t;

  // Black cell: merge group (gi,pi) with the lower group (gk,pk); returns {g,p}.
  function automatic logic [1:0] black_combine(input logic gi, input logic pi,
                                               input logic gk, input logic pk);
    return {gi | (pi & gk), pi & pk};
  endfunction

  // Number of prefix levels needed to span a WIDTH-bit operand.
  function automatic int ksa_levels(input int width);
    int n;
    n = 0;
    while ((1 << n) < width) n++;
    return n;
  endfunction

endpackage

// File: rtl/ksa_prefix_level.sv
// One combinational Kogge-Stone prefix level at distance DIST.
// Bits below DIST already hold their final group terms and pass through.
module ksa_prefix_level
  import ksa_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] i_g,
  input  logic [WIDTH-1:0] i_p,
  output logic [WIDTH-1:0] o_g,
  output logic [WIDTH-1:0] o_p
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i < DIST) begin : g_pass
      assign o_g[i] = i_g[i];
      assign o_p[i] = i_p[i];
    end else begin : g_black
      logic [1:0] w_gp;
      assign w_gp   = black_combine(i_g[i], i_p[i], i_g[i-DIST], i_p[i-DIST]);
      assign o_g[i] = w_gp[1];
      assign o_p[i] = w_gp[0];
    end
  end

endmodule

// File: rtl/ksa_pipe_adder.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready backpressure.
// Latency is LEVELS+2 enabled cycles: input stage, one register per prefix
// level, output stage. The whole pipe advances together (no bubble squeezing).
// Optional macro KSA_PIPE_FLAGS_EN adds registered o_zero / o_neg outputs.
module ksa_pipe_adder
  import ksa_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  input  logic             i_cin,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
`ifdef KSA_PIPE_FLAGS_EN
  ,
  output logic             o_zero,
  output logic             o_neg
`endif
);

  localparam int LEVELS = ksa_levels(WIDTH);

  // Global advance: the pipe moves when the output slot is empty or consumed.
  logic w_en;
  assign w_en    = i_ready | ~o_valid;
  assign o_ready = w_en;

  // Operand conditioning: subtraction is A + ~B + 1.
  logic [WIDTH-1:0] w_b;
  logic             w_c0;
  logic [WIDTH-1:0] w_g_in;
  logic [WIDTH-1:0] w_p_in;

  assign w_b    = i_sub ? ~i_b : i_b;
  assign w_c0   = i_sub | i_cin;
  assign w_p_in = i_a ^ w_b;
  // Carry-in folded into bit 0 so the prefix tree needs no extra column.
  assign w_g_in = {i_a[WIDTH-1:1] & w_b[WIDTH-1:1],
                   (i_a[0] & w_b[0]) | (w_p_in[0] & w_c0)};

  // ---- stage 0: input register ----
  logic [WIDTH-1:0] r_g_p0;
  logic [WIDTH-1:0] r_p_p0;
  logic [WIDTH-1:0] r_po_p0;
  logic             r_amsb_p0;
  logic             r_bmsb_p0;
  logic             r_c0_p0;
  logic             r_vld_p0;

  // Capture conditioned operands and the incoming valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_g_p0    <= '0;
      r_p_p0    <= '0;
      r_po_p0   <= '0;
      r_amsb_p0 <= 1'b0;
      r_bmsb_p0 <= 1'b0;
      r_c0_p0   <= 1'b0;
      r_vld_p0  <= 1'b0;
    end else if (w_en) begin
      r_g_p0    <= w_g_in;
      r_p_p0    <= w_p_in;
      r_po_p0   <= w_p_in;
      r_amsb_p0 <= i_a[WIDTH-1];
      r_bmsb_p0 <= w_b[WIDTH-1];
      r_c0_p0   <= w_c0;
      r_vld_p0  <= i_valid;
    end
  end

  // ---- stages 1..LEVELS: prefix levels ----
  logic [LEVELS:1][WIDTH-1:0]   w_g_pl;
  logic [LEVELS:1][WIDTH-1:0]   w_p_pl;
  logic [LEVELS:1][WIDTH-1:0]   r_g_pl;
  logic [LEVELS-1:1][WIDTH-1:0] r_p_pl;
  logic [LEVELS:1][WIDTH-1:0]   r_po_pl;
  logic [LEVELS:1]              r_amsb_pl;
  logic [LEVELS:1]              r_bmsb_pl;
  logic [LEVELS:1]              r_c0_pl;
  logic [LEVELS:1]              r_vld_pl;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    logic [WIDTH-1:0] w_gi;
    logic [WIDTH-1:0] w_pi;
    if (k == 1) begin : g_first
      assign w_gi = r_g_p0;
      assign w_pi = r_p_p0;
    end else begin : g_rest
      assign w_gi = r_g_pl[k-1];
      assign w_pi = r_p_pl[k-1];
    end
    ksa_prefix_level #(
      .WIDTH (WIDTH),
      .DIST  (1 << (k - 1))
    ) u_lvl (
      .i_g (w_gi),
      .i_p (w_pi),
      .o_g (w_g_pl[k]),
      .o_p (w_p_pl[k])
    );
  end

  // The final level's group propagate has no consumer.
  logic w_unused_p;
  assign w_unused_p = ^w_p_pl[LEVELS];

  // Register every prefix level and shift the side-band fields alongside.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_g_pl    <= '0;
      r_p_pl    <= '0;
      r_po_pl   <= '0;
      r_amsb_pl <= '0;
      r_bmsb_pl <= '0;
      r_c0_pl   <= '0;
      r_vld_pl  <= '0;
    end else if (w_en) begin
      r_g_pl    <= w_g_pl;
      r_p_pl    <= w_p_pl[LEVELS-1:1];
      r_po_pl   <= {r_po_pl[LEVELS-1:1], r_po_p0};
      r_amsb_pl <= {r_amsb_pl[LEVELS-1:1], r_amsb_p0};
      r_bmsb_pl <= {r_bmsb_pl[LEVELS-1:1], r_bmsb_p0};
      r_c0_pl   <= {r_c0_pl[LEVELS-1:1], r_c0_p0};
      r_vld_pl  <= {r_vld_pl[LEVELS-1:1], r_vld_p0};
    end
  end

  // ---- output stage ----
  // After the last level G[i] is the carry out of bit i.
  logic [WIDTH-1:0] w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;

  assign w_carry = r_g_pl[LEVELS];
  assign w_sum   = r_po_pl[LEVELS] ^ {w_carry[WIDTH-2:0], r_c0_pl[LEVELS]};
  assign w_cout  = w_carry[WIDTH-1];
  assign w_ovf   = (r_amsb_pl[LEVELS] == r_bmsb_pl[LEVELS]) &
                   (w_sum[WIDTH-1] != r_amsb_pl[LEVELS]);

  logic [WIDTH-1:0] r_sum_po;
  logic             r_cout_po;
  logic             r_ovf_po;
  logic             r_vld_po;

  // Form sum, carry-out and signed overflow into the output register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sum_po  <= '0;
      r_cout_po <= 1'b0;
      r_ovf_po  <= 1'b0;
      r_vld_po  <= 1'b0;
    end else if (w_en) begin
      r_sum_po  <= w_sum;
      r_cout_po <= w_cout;
      r_ovf_po  <= w_ovf;
      r_vld_po  <= r_vld_pl[LEVELS];
    end
  end

  assign o_sum   = r_sum_po;
  assign o_cout  = r_cout_po;
  assign o_ovf   = r_ovf_po;
  assign o_valid = r_vld_po;

`ifdef KSA_PIPE_FLAGS_EN
  logic r_zero_po;
  logic r_neg_po;

  // Result flags registered with the sum so they share its valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_zero_po <= 1'b0;
      r_neg_po  <= 1'b0;
    end else if (w_en) begin
      r_zero_po <= (w_sum == '0);
      r_neg_po  <= w_sum[WIDTH-1];
    end
  end

  assign o_zero = r_zero_po;
  assign o_neg  = r_neg_po;
`endif

endmodule

// File: tb/tb_ksa_pipe_adder.sv
// Bench for ksa_pipe_adder: WIDTH=32 checked against an arithmetic model on
// every consumed result, plus directed WIDTH=8 / WIDTH=64 instances.
module tb_ksa_pipe_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // WIDTH = 32
  logic        v32, rdy32, ir32, sub32, cin32, vo32, cout32, ovf32;
  logic [31:0] a32, b32, sum32;
  // WIDTH = 8
  logic        v8, rdy8, ir8, sub8, cin8, vo8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;
  // WIDTH = 64
  logic        v64, rdy64, ir64, sub64, cin64, vo64, cout64, ovf64;
  logic [63:0] a64, b64, sum64;
`ifdef KSA_PIPE_FLAGS_EN
  logic zero32, neg32, zero8, neg8, zero64, neg64;
`endif

  ksa_pipe_adder #(.WIDTH(32)) u_dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v32), .o_ready(rdy32),
    .i_a(a32), .i_b(b32), .i_sub(sub32), .i_cin(cin32),
    .o_valid(vo32), .i_ready(ir32), .o_sum(sum32), .o_cout(cout32), .o_ovf(ovf32)
`ifdef KSA_PIPE_FLAGS_EN
    , .o_zero(zero32), .o_neg(neg32)
`endif
  );

  ksa_pipe_adder #(.WIDTH(8)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v8), .o_ready(rdy8),
    .i_a(a8), .i_b(b8), .i_sub(sub8), .i_cin(cin8),
    .o_valid(vo8), .i_ready(ir8), .o_sum(sum8), .o_cout(cout8), .o_ovf(ovf8)
`ifdef KSA_PIPE_FLAGS_EN
    , .o_zero(zero8), .o_neg(neg8)
`endif
  );

  ksa_pipe_adder #(.WIDTH(64)) u_dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v64), .o_ready(rdy64),
    .i_a(a64), .i_b(b64), .i_sub(sub64), .i_cin(cin64),
    .o_valid(vo64), .i_ready(ir64), .o_sum(sum64), .o_cout(cout64), .o_ovf(ovf64)
`ifdef KSA_PIPE_FLAGS_EN
    , .o_zero(zero64), .o_neg(neg64)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain modular and signed arithmetic.
  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          tag;
  } exp_t;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 64'sd1;

  function automatic exp_t model32(input logic [31:0] a, input logic [31:0] b,
                                   input logic sub, input logic cin);
    exp_t        e;
    longint      sa, sb, r;
    logic [32:0] wide;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      e.sum  = a - b;
      e.cout = (a >= b);
      r      = sa - sb;
    end else begin
      wide   = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      e.sum  = wide[31:0];
      e.cout = wide[32];
      r      = sa + sb + (cin ? 64'sd1 : 64'sd0);
    end
    e.ovf = (r > SMAX) || (r < SMIN);
    e.tag = 0;
    return e;
  endfunction

  // Scoreboard / compare process for the 32-bit instance.
  exp_t        q[$];
  int          ecnt = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_sum;
  logic        prev_cout, prev_ovf;
  logic        m_en;
  exp_t        m_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      m_en = ir32 | ~vo32;
      chk("o_ready", rdy32, m_en);
      if (prev_stall) begin
        chk("hold_valid", vo32, 1);
        chk("hold_sum", sum32, prev_sum);
        chk("hold_cout", cout32, prev_cout);
        chk("hold_ovf", ovf32, prev_ovf);
      end
      if (vo32 && ir32) begin
        if (q.size() == 0) begin
          chk("stale_valid", vo32, 0);
        end else begin
          m_e = q.pop_front();
          chk("sum", sum32, m_e.sum);
          chk("cout", cout32, m_e.cout);
          chk("ovf", ovf32, m_e.ovf);
          chk("latency", 64'(ecnt - m_e.tag), 7);
`ifdef KSA_PIPE_FLAGS_EN
          chk("zero", zero32, (m_e.sum == 32'd0));
          chk("neg", neg32, m_e.sum[31]);
`endif
        end
      end
      if (v32 && m_en) begin
        m_e     = model32(a32, b32, sub32, cin32);
        m_e.tag = ecnt;
        q.push_back(m_e);
      end
      prev_stall = vo32 && !ir32;
      prev_sum   = sum32;
      prev_cout  = cout32;
      prev_ovf   = ovf32;
      if (m_en) ecnt++;
    end
  end

  task automatic drive_rand();
    a32   = $urandom;
    b32   = $urandom;
    sub32 = 1'($urandom_range(0, 1));
    cin32 = 1'($urandom_range(0, 1));
  endtask

  // Present one random op and hold it until accepted.
  task automatic push_rand();
    logic acc;
    int   t;
    drive_rand();
    v32 = 1'b1;
    acc = 1'b0;
    t   = 0;
    while (!acc && t < 100) begin
      @(negedge clk);
      acc = rdy32;
      @(posedge clk);
      #1;
      t++;
    end
    chk("push_accept", acc, 1);
    v32 = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 80) begin
      @(posedge clk);
      t++;
    end
    chk("drain_empty", 64'(q.size()), 0);
    @(negedge clk);
    chk("idle_valid", vo32, 0);
  endtask

  // Single op through an empty 32-bit pipe with literal expectations.
  task automatic send_lit(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic cin, input logic [31:0] es,
                          input logic ec, input logic eo);
    int lat;
    @(posedge clk); #1;
    a32 = a; b32 = b; sub32 = sub; cin32 = cin; v32 = 1'b1; ir32 = 1'b1;
    @(posedge clk);
    lat = 1;
    #1 v32 = 1'b0;
    while (!vo32 && lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
    end
    chk({nm, "_lat"}, 64'(lat), 7);
    chk({nm, "_sum"}, sum32, es);
    chk({nm, "_cout"}, cout32, ec);
    chk({nm, "_ovf"}, ovf32, eo);
`ifdef KSA_PIPE_FLAGS_EN
    chk({nm, "_zero"}, zero32, (es == 32'd0));
    chk({nm, "_neg"}, neg32, es[31]);
`endif
  endtask

  // Single add/sub through the 8- or 64-bit instance.
  task automatic run_small(input string nm, input int w, input logic [63:0] a,
                           input logic [63:0] b, input logic sub, input logic [63:0] es,
                           input logic ec, input logic eo, input int elat);
    int lat;
    @(posedge clk); #1;
    if (w == 8) begin a8 = a[7:0]; b8 = b[7:0]; sub8 = sub; v8 = 1'b1; end
    else        begin a64 = a;     b64 = b;     sub64 = sub; v64 = 1'b1; end
    @(posedge clk);
    lat = 1;
    #1 v8 = 1'b0; v64 = 1'b0;
    while (((w == 8) ? vo8 : vo64) == 1'b0 && lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
    end
    chk({nm, "_lat"}, 64'(lat), 64'(elat));
    chk({nm, "_sum"}, (w == 8) ? {56'd0, sum8} : sum64, es);
    chk({nm, "_cout"}, (w == 8) ? cout8 : cout64, ec);
    chk({nm, "_ovf"}, (w == 8) ? ovf8 : ovf64, eo);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  exp_t pin;
  int   first, nv, last;

  initial begin
    rst_n = 1'b0;
    v32 = 0; ir32 = 1; sub32 = 0; cin32 = 0; a32 = '0; b32 = '0;
    v8  = 0; ir8  = 1; sub8  = 0; cin8  = 0; a8  = '0; b8  = '0;
    v64 = 0; ir64 = 1; sub64 = 0; cin64 = 0; a64 = '0; b64 = '0;
    #1;
    chk("rst_valid", vo32, 0);
    chk("rst_sum", sum32, 0);
    chk("rst_cout", cout32, 0);
    chk("rst_ovf", ovf32, 0);
    chk("rst_ready", rdy32, 1);
    chk("rst_valid8", vo8, 0);
    chk("rst_ready8", rdy8, 1);
    chk("rst_valid64", vo64, 0);
    chk("rst_ready64", rdy64, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Pin the model against hand-computed values.
    pin = model32(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("model_wrap_sum", pin.sum, 32'h0);
    chk("model_wrap_cout", pin.cout, 1);
    pin = model32(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    chk("model_ovf", pin.ovf, 1);
    pin = model32(32'd5, 32'd7, 1'b1, 1'b1);
    chk("model_sub_sum", pin.sum, 32'hFFFF_FFFE);
    chk("model_sub_cout", pin.cout, 0);

    // Directed vectors.
    send_lit("wrap",    32'h0000_0001, 32'hFFFF_FFFF, 0, 0, 32'h0000_0000, 1, 0);
    send_lit("posovf",  32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 32'h8000_0000, 0, 1);
    send_lit("sub57",   32'd5,         32'd7,         1, 0, 32'hFFFF_FFFE, 0, 0);
    send_lit("sub77",   32'd7,         32'd7,         1, 0, 32'h0000_0000, 1, 0);
    send_lit("cin",     32'hFFFF_FFFF, 32'h0000_0000, 0, 1, 32'h0000_0000, 1, 0);
    send_lit("subcin",  32'd5,         32'd7,         1, 1, 32'hFFFF_FFFE, 0, 0);
    send_lit("subovf",  32'h8000_0000, 32'h0000_0001, 1, 0, 32'h7FFF_FFFF, 1, 1);
    drain();

    // Back-to-back stream of 20 random ops, no backpressure.
    @(posedge clk); #1;
    ir32 = 1'b1;
    drive_rand();
    v32 = 1'b1;
    first = 0; nv = 0; last = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (vo32) begin
        if (first == 0) first = k;
        nv++;
        last = k;
      end
      if (k < 20) drive_rand();
      else        v32 = 1'b0;
    end
    chk("stream_first", 64'(first), 7);
    chk("stream_count", 64'(nv), 20);
    chk("stream_last", 64'(last), 26);
    drain();

    // Fill the pipe with i_ready low, stall 5 cycles, then release.
    @(posedge clk); #1;
    ir32 = 1'b0;
    fork
      begin
        for (int n = 0; n < 10; n++) push_rand();
      end
      begin
        int t;
        t = 0;
        @(negedge clk);
        while (rdy32 && t < 50) begin
          @(negedge clk);
          t++;
        end
        chk("fill_stall", rdy32, 0);
        for (int s = 0; s < 4; s++) begin
          @(negedge clk);
          chk("stall_ready", rdy32, 0);
          chk("stall_valid", vo32, 1);
        end
        @(posedge clk); #1;
        ir32 = 1'b1;
      end
    join
    drain();

    // Asynchronous reset in the middle of a stream.
    @(posedge clk); #1;
    ir32 = 1'b1;
    for (int n = 0; n < 4; n++) push_rand();
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("midrst_valid", vo32, 0);
    chk("midrst_sum", sum32, 0);
    chk("midrst_cout", cout32, 0);
    chk("midrst_ovf", ovf32, 0);
    chk("midrst_ready", rdy32, 1);
    chk("midrst_valid8", vo8, 0);
    chk("midrst_valid64", vo64, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_lit("after_rst", 32'd3, 32'd4, 0, 0, 32'd7, 0, 0);
    drain();

    // Other widths: latency LEVELS+2.
    run_small("w8_add",  8,  64'd3,    64'd4, 0, 64'd7,    0, 0, 5);
    run_small("w8_ovf",  8,  64'h7F,   64'h1, 0, 64'h80,   0, 1, 5);
    run_small("w8_sub",  8,  64'd5,    64'd7, 1, 64'hFE,   0, 0, 5);
    run_small("w64_add", 64, 64'd3,    64'd4, 0, 64'd7,    0, 0, 8);
    run_small("w64_wrap", 64, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 64'd0, 1, 0, 8);
    run_small("w64_sub", 64, 64'd9,    64'd9, 1, 64'd0,    1, 0, 8);

    @(negedge clk);
    chk("final_queue", 64'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
